miss_refill_ctrl: RTL and testbench

Memory-side miss handler for the processor's 2-way, 4-word-block data cache (18-bit tag, 10-bit set, 2-bit block offset). On a cache miss it writes back the victim block over a word-serial req/ack memory port, then fetches the requested block. It returns the block to the cache as a one-cycle fill pulse and stalls the pipeline for the whole transaction.

---
 rtl/miss_refill_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_miss_refill_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miss_refill_ctrl.sv
// ---------------------------------------------------------------------------
// miss_refill_ctrl
//
// Miss handler for a 2-way, 4-word-block data cache.  On a miss it writes the
// LRU victim block back to memory (if valid) over a word-serial req/ack port,
// then reads the requested block and hands it to the cache as a one-cycle
// fill pulse.  The pipeline is stalled for the whole transaction, including
// the miss cycle itself.
//
// Build option:
//   CRITICAL_WORD_FIRST_EN  - when defined, read beats start at the missing
//                             word offset and wrap (off, off+1, off+2, off+3).
//                             Write-back order and fill word placement are
//                             unaffected.  Undefined: reads go 0,1,2,3.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   miss_req                   miss this cycle (only looked at in IDLE)
//   req_tag/req_set/req_offset missing address fields
//   victim_valid/_tag/_data    LRU way contents for req_set
//   stall                      pipeline freeze (combinational)
//   fill_valid/_data/_tag      one-cycle block return to the cache
//   mem_req/_we/_addr/_wdata   registered memory beat request
//   mem_rdata/mem_ack          memory read data / beat completion
// ---------------------------------------------------------------------------
module miss_refill_ctrl #(
    parameter int TAG_W = 18,
    parameter int SET_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             miss_req,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [SET_W-1:0] req_set,
    input  logic [1:0]       req_offset,
    input  logic             victim_valid,
    input  logic [TAG_W-1:0] victim_tag,
    input  logic [127:0]     victim_data,
    output logic             stall,
    output logic             fill_valid,
    output logic [127:0]     fill_data,
    output logic [TAG_W-1:0] fill_tag,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WB   = 2'b01,
        ST_RD   = 2'b10,
        ST_FILL = 2'b11
    } state_t;

    // The captured offset only steers the read order when critical-word-first
    // is built in; otherwise it is masked to zero.
`ifdef CRITICAL_WORD_FIRST_EN
    localparam logic [1:0] CWF_MASK = 2'b11;
`else
    localparam logic [1:0] CWF_MASK = 2'b00;
`endif

    state_t             state_q, state_d;
    logic [1:0]         beat_q, beat_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [SET_W-1:0]   set_q, set_d;
    logic [1:0]         off_q, off_d;
    logic [TAG_W-1:0]   vtag_q, vtag_d;
    logic [127:0]       vdata_q, vdata_d;
    logic [127:0]       data_q, data_d;
    logic               fill_valid_q, fill_valid_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;

    logic               beat_fire_s;
    logic [1:0]         beat_nxt_s;
    logic [1:0]         rd_idx_s;
    logic [1:0]         rd_nxt_idx_s;

    assign beat_fire_s  = mem_req_q & mem_ack;
    assign beat_nxt_s   = beat_q + 2'd1;
    // Absolute word index of the current / next read beat.
    assign rd_idx_s     = beat_q + (off_q & CWF_MASK);
    assign rd_nxt_idx_s = beat_nxt_s + (off_q & CWF_MASK);

    // Pipeline freezes in the miss cycle itself and for every non-IDLE cycle.
    assign stall      = (state_q != ST_IDLE) | ((state_q == ST_IDLE) & miss_req);
    assign fill_valid = fill_valid_q;
    assign fill_data  = data_q;
    assign fill_tag   = tag_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

    // Next-state, next-beat and next memory-request computation.
    // Memory request fields are computed one cycle ahead so they are
    // registered and already correct in the first cycle of each beat.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        tag_d        = tag_q;
        set_d        = set_q;
        off_d        = off_q;
        vtag_d       = vtag_q;
        vdata_d      = vdata_q;
        data_d       = data_q;
        fill_valid_d = 1'b0;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (miss_req) begin
                    tag_d     = req_tag;
                    set_d     = req_set;
                    off_d     = req_offset;
                    vtag_d    = victim_tag;
                    vdata_d   = victim_data;
                    beat_d    = 2'd0;
                    mem_req_d = 1'b1;
                    if (victim_valid) begin
                        state_d     = ST_WB;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {victim_tag, req_set, 2'b00, 2'b00};
                        mem_wdata_d = victim_data[31:0];
                    end else begin
                        state_d    = ST_RD;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {req_tag, req_set, (req_offset & CWF_MASK), 2'b00};
                    end
                end else begin
                    mem_req_d = 1'b0;
                end
            end

            ST_WB: begin
                if (beat_fire_s) begin
                    if (beat_q == 2'd3) begin
                        state_d    = ST_RD;
                        beat_d     = 2'd0;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {tag_q, set_q, (off_q & CWF_MASK), 2'b00};
                    end else begin
                        beat_d      = beat_nxt_s;
                        mem_addr_d  = {vtag_q, set_q, beat_nxt_s, 2'b00};
                        mem_wdata_d = vdata_q[{beat_nxt_s, 5'b00000} +: 32];
                    end
                end else begin
                    beat_d = beat_q;
                end
            end

            ST_RD: begin
                if (beat_fire_s) begin
                    // Words land at their absolute position regardless of order.
                    data_d[{rd_idx_s, 5'b00000} +: 32] = mem_rdata;
                    if (beat_q == 2'd3) begin
                        state_d      = ST_FILL;
                        beat_d       = 2'd0;
                        mem_req_d    = 1'b0;
                        fill_valid_d = 1'b1;
                    end else begin
                        beat_d     = beat_nxt_s;
                        mem_addr_d = {tag_q, set_q, rd_nxt_idx_s, 2'b00};
                    end
                end else begin
                    beat_d = beat_q;
                end
            end

            ST_FILL: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            beat_q       <= 2'd0;
            tag_q        <= {TAG_W{1'b0}};
            set_q        <= {SET_W{1'b0}};
            off_q        <= 2'd0;
            vtag_q       <= {TAG_W{1'b0}};
            vdata_q      <= 128'd0;
            data_q       <= 128'd0;
            fill_valid_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            tag_q        <= tag_d;
            set_q        <= set_d;
            off_q        <= off_d;
            vtag_q       <= vtag_d;
            vdata_q      <= vdata_d;
            data_q       <= data_d;
            fill_valid_q <= fill_valid_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_miss_refill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_miss_refill_ctrl
//
// Self-checking bench for miss_refill_ctrl.  A word-addressed memory model
// (associative array) answers beats with optional wait cycles; for each miss
// the expected beat list, fill cycle, fill data and stall length are derived
// from the transaction rules and compared against what the DUT does.
// ---------------------------------------------------------------------------
module tb_miss_refill_ctrl;

    localparam int TAG_W = 18;
    localparam int SET_W = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             miss_req;
    logic [TAG_W-1:0] req_tag;
    logic [SET_W-1:0] req_set;
    logic [1:0]       req_offset;
    logic             victim_valid;
    logic [TAG_W-1:0] victim_tag;
    logic [127:0]     victim_data;
    logic             stall;
    logic             fill_valid;
    logic [127:0]     fill_data;
    logic [TAG_W-1:0] fill_tag;
    logic             mem_req;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;
    logic             mem_ack;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [logic [31:0]];

    miss_refill_ctrl #(.TAG_W(TAG_W), .SET_W(SET_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .miss_req     (miss_req),
        .req_tag      (req_tag),
        .req_set      (req_set),
        .req_offset   (req_offset),
        .victim_valid (victim_valid),
        .victim_tag   (victim_tag),
        .victim_data  (victim_data),
        .stall        (stall),
        .fill_valid   (fill_valid),
        .fill_data    (fill_data),
        .fill_tag     (fill_tag),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] addr_of(input logic [TAG_W-1:0] t, input logic [SET_W-1:0] s, input int w);
        logic [1:0] wi;
        wi = 2'(w);
        return {t, s, wi, 2'b00};
    endfunction

    function automatic int pick_wait(input int wmode);
        if (wmode < 0) return int'($urandom_range(0, 2));
        return wmode;
    endfunction

    // One complete miss transaction starting in the current (IDLE) cycle.
    // wmode: fixed wait cycles per beat, or -1 for random 0..2.
    // noise: pulse miss_req during a read beat and in the fill cycle.
    task automatic run_miss(input bit vv, input logic [TAG_W-1:0] vtag, input logic [127:0] vdata,
                            input logic [TAG_W-1:0] tag, input logic [SET_W-1:0] set,
                            input logic [1:0] off, input int wmode, input bit noise);
        logic [31:0]  e_addr [$];
        bit           e_we [$];
        logic [31:0]  e_wd [$];
        logic [127:0] e_fill;
        int           beat, waits_left, cur_w, exp_fill_cyc, fill_cyc, stall_cnt, unstable, w;
        bit           waiting, done;
        logic [31:0]  hold_addr, hold_wd;

        if (vv) begin
            for (int i = 0; i < 4; i++) begin
                e_addr.push_back(addr_of(vtag, set, i));
                e_we.push_back(1'b1);
                e_wd.push_back(vdata[32*i +: 32]);
            end
        end
        for (int i = 0; i < 4; i++) begin
`ifdef CRITICAL_WORD_FIRST_EN
            w = (int'(off) + i) % 4;
`else
            w = i;
`endif
            e_addr.push_back(addr_of(tag, set, w));
            e_we.push_back(1'b0);
            e_wd.push_back(32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            if (vv && (vtag == tag)) e_fill[32*i +: 32] = vdata[32*i +: 32];
            else                     e_fill[32*i +: 32] = mem_rd(addr_of(tag, set, i));
        end

        // cycle 0: the miss
        miss_req     = 1'b1;
        victim_valid = vv;
        victim_tag   = vtag;
        victim_data  = vdata;
        req_tag      = tag;
        req_set      = set;
        req_offset   = off;
        mem_ack      = 1'b0;
        #1;
        chk("stall_miss_cycle", 128'(stall), 128'(1));
        chk("req_low_miss_cycle", 128'(mem_req), 128'(0));

        beat = 0; cur_w = pick_wait(wmode); waits_left = cur_w;
        exp_fill_cyc = 1; fill_cyc = -1; stall_cnt = 1; unstable = 0;
        waiting = 1'b0; done = 1'b0; hold_addr = 32'h0; hold_wd = 32'h0;

        for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
            @(posedge clk); #1;
            miss_req     = 1'b0;
            mem_ack      = 1'b0;
            mem_rdata    = $urandom;
            // Inputs outside IDLE must not matter.
            req_tag      = TAG_W'($urandom);
            req_set      = SET_W'($urandom);
            req_offset   = 2'($urandom);
            victim_valid = 1'($urandom);
            victim_tag   = TAG_W'($urandom);
            victim_data  = {$urandom, $urandom, $urandom, $urandom};
            #1;
            if (stall) stall_cnt++;
            if (fill_cyc >= 0) begin
                chk("stall_after_fill", 128'(stall), 128'(0));
                chk("fill_one_cycle", 128'(fill_valid), 128'(0));
                chk("fill_data_held", fill_data, e_fill);
                done = 1'b1;
            end else if (fill_valid) begin
                fill_cyc = cyc;
                chk("fill_data", fill_data, e_fill);
                chk("fill_tag", 128'(fill_tag), 128'(tag));
                chk("fill_cycle", 128'(fill_cyc), 128'(exp_fill_cyc));
                chk("beat_count", 128'(beat), 128'(e_addr.size()));
                chk("req_low_fill", 128'(mem_req), 128'(0));
                mem_ack = 1'($urandom);   // ack with no request is ignored
                if (noise) miss_req = 1'b1;
            end else if (mem_req) begin
                if (beat >= e_addr.size()) begin
                    chk("extra_beat", 128'(beat), 128'(e_addr.size()));
                    done = 1'b1;
                end else begin
                    if (waiting && (mem_addr !== hold_addr || mem_wdata !== hold_wd)) unstable++;
                    if (noise && !mem_we && beat == (vv ? 5 : 1)) miss_req = 1'b1;
                    if (waits_left == 0) begin
                        chk("beat_addr", 128'(mem_addr), 128'(e_addr[beat]));
                        chk("beat_we", 128'(mem_we), 128'(e_we[beat]));
                        if (e_we[beat]) begin
                            chk("beat_wdata", 128'(mem_wdata), 128'(e_wd[beat]));
                            mem[mem_addr] = mem_wdata;
                        end else begin
                            mem_rdata = mem_rd(mem_addr);
                        end
                        mem_ack = 1'b1;
                        exp_fill_cyc += 1 + cur_w;
                        beat++;
                        cur_w = pick_wait(wmode);
                        waits_left = cur_w;
                        waiting = 1'b0;
                    end else begin
                        waits_left--;
                        waiting = 1'b1;
                        hold_addr = mem_addr;
                        hold_wd   = mem_wdata;
                    end
                end
            end else begin
                chk("req_gap", 128'(mem_req), 128'(1));
                done = 1'b1;
            end
            #1;
        end
        miss_req = 1'b0;
        mem_ack  = 1'b0;
        chk("fill_seen", 128'(fill_cyc >= 0), 128'(1));
        chk("stall_cycles", 128'(stall_cnt), 128'(exp_fill_cyc + 1));
        chk("wait_stable", 128'(unstable), 128'(0));
    endtask

    initial begin
        int bad;
        reset = 1'b1; miss_req = 1'b0; req_tag = '0; req_set = '0; req_offset = 2'd0;
        victim_valid = 1'b0; victim_tag = '0; victim_data = 128'd0;
        mem_rdata = 32'd0; mem_ack = 1'b0;
        #1;
        chk("rst_stall", 128'(stall), 128'(0));
        chk("rst_fill_valid", 128'(fill_valid), 128'(0));
        chk("rst_fill_data", fill_data, 128'd0);
        chk("rst_fill_tag", 128'(fill_tag), 128'(0));
        chk("rst_mem_req", 128'(mem_req), 128'(0));
        chk("rst_mem_we", 128'(mem_we), 128'(0));
        chk("rst_mem_addr", 128'(mem_addr), 128'(0));
        chk("rst_mem_wdata", 128'(mem_wdata), 128'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Cold miss, memory returns 0x11111111*(i+1) at word i.
        for (int i = 0; i < 4; i++) mem[addr_of(18'h00ABC, 10'h155, i)] = 32'h1111_1111 * (i + 1);
        run_miss(1'b0, 18'h0, 128'd0, 18'h00ABC, 10'h155, 2'd0, 0, 1'b0);
        chk("cold_fill_const", fill_data, 128'h44444444_33333333_22222222_11111111);

        // Dirty victim, zero wait.
        run_miss(1'b1, 18'h00001, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA,
                 18'h00002, 10'h001, 2'd0, 0, 1'b0);
        // Dirty victim, 2 wait cycles per beat.
        run_miss(1'b1, 18'h00011, {$urandom, $urandom, $urandom, $urandom},
                 18'h00022, 10'h0F0, 2'd1, 2, 1'b0);
        // Spurious miss_req during RD and FILL, then a back-to-back miss.
        run_miss(1'b1, 18'h00333, {$urandom, $urandom, $urandom, $urandom},
                 18'h00444, 10'h3C3, 2'd2, 0, 1'b1);
        run_miss(1'b0, 18'h0, 128'd0, 18'h00555, 10'h3C3, 2'd1, 0, 1'b0);

        // Reset during the third write-back beat.
        miss_req = 1'b1; victim_valid = 1'b1; victim_tag = 18'h00003;
        victim_data = {$urandom, $urandom, $urandom, $urandom};
        req_tag = 18'h00007; req_set = 10'h02A; req_offset = 2'd0; mem_ack = 1'b0;
        @(posedge clk); #1; miss_req = 1'b0; mem_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_mid_req_before", 128'(mem_req), 128'(1));
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_req", 128'(mem_req), 128'(0));
        chk("rst_mid_stall", 128'(stall), 128'(0));
        chk("rst_mid_fill", 128'(fill_valid), 128'(0));
        mem_ack = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (fill_valid || mem_req || stall) bad++;
        end
        chk("rst_no_fill_after", 128'(bad), 128'(0));
        run_miss(1'b1, 18'h00003, {$urandom, $urandom, $urandom, $urandom},
                 18'h00007, 10'h02A, 2'd0, 0, 1'b0);

        // Offset 3: critical-word-first order when enabled, 0..3 otherwise.
        run_miss(1'b0, 18'h0, 128'd0, 18'h2_1234, 10'h2B7, 2'd3, 0, 1'b0);
        run_miss(1'b1, 18'h1_0F0F, {$urandom, $urandom, $urandom, $urandom},
                 18'h0_7777, 10'h011, 2'd3, 1, 1'b0);

        // Randomized transactions.
        for (int n = 0; n < 20; n++) begin
            run_miss(1'($urandom), TAG_W'($urandom), {$urandom, $urandom, $urandom, $urandom},
                     TAG_W'($urandom), SET_W'($urandom), 2'($urandom), -1, 1'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
